// File: rtl/fc_ibuf_pkg.sv
// Shared constants, helpers and types for the fully-connected input buffer.
package fc_ibuf_pkg;

  // Lifecycle of one storage bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Beats needed to fill one bank.
  function automatic int fifo_length(input int xbar_size, input int data_size);
    return xbar_size / data_size;
  endfunction

  // Number of input channels (previous-layer horizontal tiles).
  function automatic int ch(input int input_neurons, input int fl);
    return (input_neurons + fl - 1) / fl;
  endfunction

  // Vertical tiles of this layer, never fewer than one.
  function automatic int v_tiles(input int input_neurons, input int xbar_size);
    int t;
    t = (input_neurons + xbar_size - 1) / xbar_size;
    return (t < 1) ? 1 : t;
  endfunction

  // Slices per element.
  function automatic int num_slices(input int data_size, input int slice_bits);
    return data_size / slice_bits;
  endfunction

  // Output words per slice.
  function automatic int num_addr(input int fl, input int chans, input int slice_bits,
                                  input int out_w);
    return (fl * chans * slice_bits + out_w - 1) / out_w;
  endfunction

  // Counter width that is at least one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Elaboration-time legality of the slice width.
  function automatic bit slice_bits_ok(input int data_size, input int slice_bits);
    return (slice_bits > 0) && ((data_size % slice_bits) == 0);
  endfunction

endpackage

// File: rtl/fc_ibuf_bank.sv
// One storage bank: beat-indexed parallel write of all channels, and a
// combinational read of one OUT_W word selected by slice and address.
module fc_ibuf_bank
  import fc_ibuf_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int FIFO_LENGTH = 16,
  parameter int CH          = 8,
  parameter int SLICE_BITS  = 1,
  parameter int OUT_W       = 16,
  parameter int NUM_ADDR    = 8,
  parameter int BEAT_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int SLICE_W     = 4
)(
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [BEAT_W-1:0]    i_beat,
  input  logic [DATA_SIZE-1:0] i_data [CH-1:0],
  input  logic [SLICE_W-1:0]   i_slice,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [OUT_W-1:0]     o_word
);

  localparam int NUM_ELEM = FIFO_LENGTH * CH;
  localparam int FLAT_W   = NUM_ADDR * OUT_W;

  logic [DATA_SIZE-1:0] r_mem [NUM_ELEM];
  logic [FLAT_W-1:0]    w_flat;

  // Store channel j's element of beat b at index j*FIFO_LENGTH + b; contents are not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int j = 0; j < CH; j++) begin
        for (int b = 0; b < FIFO_LENGTH; b++) begin
          if (i_beat == BEAT_W'(b)) begin
            r_mem[j*FIFO_LENGTH + b] <= i_data[j];
          end
        end
      end
    end
  end

  // Gather the selected slice of every element into one flat word; padding bits stay 0.
  always_comb begin
    w_flat = '0;
    for (int e = 0; e < NUM_ELEM; e++) begin
      w_flat[e*SLICE_BITS +: SLICE_BITS] =
        SLICE_BITS'(r_mem[e] >> (32'(i_slice) * SLICE_BITS));
    end
  end

  assign o_word = OUT_W'(w_flat >> (32'(i_addr) * OUT_W));

endmodule

// File: rtl/fc_ibuf_stream.sv
// Double-buffered, bit-sliced input buffer: one bank fills from the previous
// layer while the other streams slice/address words to the crossbar drivers.
module fc_ibuf_stream
  import fc_ibuf_pkg::*;
#(
  parameter  int DATA_SIZE     = 8,
  parameter  int INPUT_NEURONS = 128,
  parameter  int XBAR_SIZE     = 128,
  parameter  int BUS_WIDTH     = 16,
  parameter  int SLICE_BITS    = 1,
  localparam int FIFO_LENGTH   = fifo_length(XBAR_SIZE, DATA_SIZE),
  localparam int CH            = ch(INPUT_NEURONS, FIFO_LENGTH),
  localparam int V_TILES       = v_tiles(INPUT_NEURONS, XBAR_SIZE),
  localparam int OUT_W         = BUS_WIDTH * V_TILES,
  localparam int NUM_SLICES    = num_slices(DATA_SIZE, SLICE_BITS),
  localparam int NUM_ADDR      = num_addr(FIFO_LENGTH, CH, SLICE_BITS, OUT_W),
  localparam int ADDR_W        = $clog2(NUM_ADDR) + 1,
  localparam int SLICE_W       = $clog2(NUM_SLICES) + 1
)(
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_SIZE-1:0] i_data [CH-1:0],
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_W-1:0]     o_data,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [SLICE_W-1:0]   o_slice,
  output logic                 o_last
);

  localparam int BEAT_W = clog2_min1(FIFO_LENGTH);

  if (!slice_bits_ok(DATA_SIZE, SLICE_BITS)) begin : g_bad_slice_bits
    $error("fc_ibuf_stream: SLICE_BITS must divide DATA_SIZE");
  end

  bank_state_t         r_state [2];
  bank_state_t         w_state_nxt [2];
  logic                r_wr_bank, w_wr_bank_nxt;
  logic                r_rd_bank, w_rd_bank_nxt;
  logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [SLICE_W-1:0]  r_slice, w_slice_nxt;

  logic                w_wr_fire, w_rd_fire;
  logic                w_beat_last, w_addr_last, w_slice_last;
  logic [OUT_W-1:0]    w_word [2];

  assign o_ready      = (r_state[r_wr_bank] != FULL);
  assign o_valid      = (r_state[r_rd_bank] == FULL);
  assign w_beat_last  = (r_beat == BEAT_W'(FIFO_LENGTH - 1));
  assign w_addr_last  = (r_addr == ADDR_W'(NUM_ADDR - 1));
  assign w_slice_last = (r_slice == SLICE_W'(NUM_SLICES - 1));
  assign o_last       = o_valid && w_addr_last && w_slice_last;
  assign o_addr       = r_addr;
  assign o_slice      = r_slice;

  // A flush cycle drops any beat or word offered alongside it.
  assign w_wr_fire = i_valid && o_ready && !i_clear;
  assign w_rd_fire = o_valid && i_ready && !i_clear;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fc_ibuf_bank #(
      .DATA_SIZE   (DATA_SIZE),
      .FIFO_LENGTH (FIFO_LENGTH),
      .CH          (CH),
      .SLICE_BITS  (SLICE_BITS),
      .OUT_W       (OUT_W),
      .NUM_ADDR    (NUM_ADDR),
      .BEAT_W      (BEAT_W),
      .ADDR_W      (ADDR_W),
      .SLICE_W     (SLICE_W)
    ) u_bank (
      .clk     (clk),
      .i_wr_en (w_wr_fire && (r_wr_bank == 1'(g))),
      .i_beat  (r_beat),
      .i_data  (i_data),
      .i_slice (r_slice),
      .i_addr  (r_addr),
      .o_word  (w_word[g])
    );
  end

  // Next-state for bank flags, bank pointers and counters; fill and stream update independently.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_bank_nxt = r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_beat_nxt    = r_beat;
    w_addr_nxt    = r_addr;
    w_slice_nxt   = r_slice;

    if (w_wr_fire) begin
      if (w_beat_last) begin
        w_state_nxt[r_wr_bank] = FULL;
        w_wr_bank_nxt          = ~r_wr_bank;
        w_beat_nxt             = '0;
      end else begin
        w_state_nxt[r_wr_bank] = FILLING;
        w_beat_nxt             = r_beat + BEAT_W'(1);
      end
    end else begin
      w_beat_nxt = r_beat;
    end

    if (w_rd_fire) begin
      if (o_last) begin
        w_state_nxt[r_rd_bank] = EMPTY;
        w_rd_bank_nxt          = ~r_rd_bank;
        w_addr_nxt             = '0;
        w_slice_nxt            = '0;
      end else if (w_addr_last) begin
        w_addr_nxt  = '0;
        w_slice_nxt = r_slice + SLICE_W'(1);
      end else begin
        w_addr_nxt = r_addr + ADDR_W'(1);
      end
    end else begin
      w_addr_nxt = r_addr;
    end
  end

  // State register: async reset, synchronous flush, otherwise take next-state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_slice    <= '0;
    end else if (i_clear) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_slice    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_beat     <= w_beat_nxt;
      r_addr     <= w_addr_nxt;
      r_slice    <= w_slice_nxt;
    end
  end

  // Output word from the streaming bank, forced to zero while nothing is valid.
  always_comb begin
    if (o_valid) begin
      o_data = r_rd_bank ? w_word[1] : w_word[0];
    end else begin
      o_data = '0;
    end
  end

endmodule

// File: tb/tb_fc_ibuf_stream.sv
// Directed bench for fc_ibuf_stream: single fill, ping-pong, backpressure,
// both banks full, 2-bit slices, and reset/flush recovery.
module tb_fc_ibuf_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr;

  // DUT A: SLICE_BITS = 1
  logic       a_valid, a_oready, a_ovalid, a_iready, a_olast;
  logic [7:0] a_data [1:0];
  logic [3:0] a_odata;
  logic [1:0] a_oaddr;
  logic [3:0] a_oslice;

  // DUT B: SLICE_BITS = 2
  logic       b_valid, b_oready, b_ovalid, b_iready, b_olast;
  logic [7:0] b_data [1:0];
  logic [3:0] b_odata;
  logic [2:0] b_oaddr;
  logic [2:0] b_oslice;

  fc_ibuf_stream #(.DATA_SIZE(8), .INPUT_NEURONS(8), .XBAR_SIZE(32), .BUS_WIDTH(4),
                   .SLICE_BITS(1)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_valid(a_valid), .o_ready(a_oready),
    .i_data(a_data), .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata),
    .o_addr(a_oaddr), .o_slice(a_oslice), .o_last(a_olast));

  fc_ibuf_stream #(.DATA_SIZE(8), .INPUT_NEURONS(8), .XBAR_SIZE(32), .BUS_WIDTH(4),
                   .SLICE_BITS(2)) dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_valid(b_valid), .o_ready(b_oready),
    .i_data(b_data), .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata),
    .o_addr(b_oaddr), .o_slice(b_oslice), .o_last(b_olast));

  int checks = 0;
  int errors = 0;

  logic [7:0] vq [4][8];
  logic [3:0] got [64];
  int beat_ptr, word_ptr, gcyc, acc4_cyc, first_valid_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference word for DUT A: bit i of word a in slice s, from flat bit position a*4+i.
  function automatic logic [3:0] exp_word(input int v, input int s, input int a, input int sb);
    logic [3:0] w;
    int p, e, k;
    w = 4'h0;
    for (int i = 0; i < 4; i++) begin
      p = a*4 + i;
      e = p / sb;
      k = p % sb;
      if (e < 8) w[i] = vq[v][e][s*sb + k];
    end
    return w;
  endfunction

  task automatic load(input int v, input logic [63:0] packed_vec);
    for (int e = 0; e < 8; e++) vq[v][e] = packed_vec[63 - 8*e -: 8];
  endtask

  // Cycle loop: feed beats up to beat_tgt, consume/check words up to word_tgt.
  // mode 0: i_ready=1, 1: toggling, 2: i_ready=0.
  task automatic run(input int mode, input int beat_tgt, input int word_tgt,
                     input bit chk_ready, input bit chk_gap, input int maxc);
    int cyc, v, r, s, a;
    bit held, started, rdy;
    logic [3:0] hd, hs;
    logic [1:0] ha;
    cyc = 0; held = 1'b0; started = 1'b0;
    while (beat_ptr < beat_tgt || word_ptr < word_tgt) begin
      if (cyc >= maxc) begin
        checks++; errors++;
        $error("FAIL timeout observed_cycles=%0d required_below=%0d", cyc, maxc);
        break;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = cyc[0];
        default: rdy = 1'b0;
      endcase
      if (word_ptr >= word_tgt) rdy = 1'b0;
      a_iready = rdy;
      if (beat_ptr < beat_tgt) begin
        a_valid   = 1'b1;
        a_data[0] = vq[beat_ptr/4][beat_ptr%4];
        a_data[1] = vq[beat_ptr/4][4 + beat_ptr%4];
      end else begin
        a_valid = 1'b0;
      end
      if (held) begin
        check("stall_data", a_odata, hd);
        check("stall_addr", a_oaddr, ha);
        check("stall_slice", a_oslice, hs);
        held = 1'b0;
      end
      if (chk_gap && started && word_ptr < word_tgt) check("no_gap_valid", a_ovalid, 1);
      if (a_ovalid) begin
        started = 1'b1;
        if (first_valid_cyc < 0) first_valid_cyc = gcyc;
      end
      if (a_ovalid && rdy) begin
        v = word_ptr / 16; r = word_ptr % 16; s = r / 2; a = r % 2;
        check("word_data", a_odata, exp_word(v, s, a, 1));
        check("word_addr", a_oaddr, a);
        check("word_slice", a_oslice, s);
        check("word_last", a_olast, (r == 15));
        got[word_ptr] = a_odata;
        word_ptr++;
      end else if (a_ovalid) begin
        held = 1'b1; hd = a_odata; ha = a_oaddr; hs = a_oslice;
      end
      if (a_valid) begin
        if (chk_ready) check("o_ready_pingpong", a_oready, 1);
        if (a_oready) begin
          beat_ptr++;
          if (beat_ptr == 4) acc4_cyc = gcyc;
        end
      end
      @(posedge clk); #1;
      cyc++; gcyc++;
    end
    a_valid = 1'b0; a_iready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    a_valid = 1'b0; a_iready = 1'b0; a_data[0] = 8'h00; a_data[1] = 8'h00;
    b_valid = 1'b0; b_iready = 1'b0; b_data[0] = 8'h00; b_data[1] = 8'h00;
    gcyc = 0; beat_ptr = 0; word_ptr = 0; acc4_cyc = -1; first_valid_cyc = -1;
    #12;
    check("rst_o_valid", a_ovalid, 0);
    check("rst_o_ready", a_oready, 1);
    check("rst_o_addr", a_oaddr, 0);
    check("rst_o_slice", a_oslice, 0);
    check("rst_o_last", a_olast, 0);
    check("rst_o_data", a_odata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SLICE_BITS=2 instance with the single-fill vector
    load(0, 64'h01020304_8000FF0F);
    for (int b = 0; b < 4; b++) begin
      b_valid = 1'b1; b_data[0] = vq[0][b]; b_data[1] = vq[0][4+b];
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    check("sb2_valid", b_ovalid, 1);
    check("sb2_s0a0", b_odata, 4'h9);
    check("sb2_addr0", b_oaddr, 0);
    check("sb2_slice0", b_oslice, 0);
    b_iready = 1'b1;
    @(posedge clk); #1;
    check("sb2_s0a1", b_odata, 4'h3);
    check("sb2_addr1", b_oaddr, 1);
    @(posedge clk); #1;
    check("sb2_s0a2", b_odata, 4'h0);
    @(posedge clk); #1;
    check("sb2_s0a3", b_odata, 4'hF);
    check("sb2_addr3", b_oaddr, 3);
    @(posedge clk); #1;
    check("sb2_s1a0", b_odata, 4'h0);
    check("sb2_slice1", b_oslice, 1);
    check("sb2_addr_wrap", b_oaddr, 0);
    repeat (11) begin @(posedge clk); #1; end
    check("sb2_last", b_olast, 1);
    @(posedge clk); #1;
    check("sb2_done_valid", b_ovalid, 0);
    check("sb2_done_ready", b_oready, 1);
    b_iready = 1'b0;

    // Single fill on DUT A
    beat_ptr = 0; word_ptr = 0; first_valid_cyc = -1;
    run(0, 4, 16, 1'b0, 1'b0, 100);
    check("latency", first_valid_cyc - acc4_cyc, 1);
    check("fill_s0a0", got[0], 4'h5);
    check("fill_s0a1", got[1], 4'hC);
    check("fill_s7a0", got[14], 4'h0);
    check("fill_s7a1", got[15], 4'h5);
    check("fill_idle", a_ovalid, 0);

    // Ping-pong: two back-to-back vectors, no gap, ready throughout
    load(0, 64'h01020304_8000FF0F);
    load(1, 64'hA53C7E11_C39600FF);
    beat_ptr = 0; word_ptr = 0;
    run(0, 8, 32, 1'b1, 1'b1, 200);

    // Backpressure: toggling i_ready
    load(0, 64'h12345678_9ABCDEF0);
    beat_ptr = 0; word_ptr = 0;
    run(1, 4, 16, 1'b0, 1'b0, 200);

    // Both banks full
    load(0, 64'h01020304_8000FF0F);
    load(1, 64'hA53C7E11_C39600FF);
    load(2, 64'h12345678_9ABCDEF0);
    beat_ptr = 0; word_ptr = 0;
    run(2, 8, 0, 1'b0, 1'b0, 100);
    a_valid = 1'b1; a_data[0] = vq[2][0]; a_data[1] = vq[2][4];
    check("full_ready_low", a_oready, 0);
    @(posedge clk); #1;
    check("full_ready_low2", a_oready, 0);
    check("full_valid", a_ovalid, 1);
    a_valid = 1'b0;
    run(0, 8, 15, 1'b0, 1'b0, 100);
    check("full_last_pending", a_olast, 1);
    check("full_ready_before_last", a_oready, 0);
    run(0, 8, 16, 1'b0, 1'b0, 10);
    check("full_ready_after_last", a_oready, 1);
    run(0, 12, 48, 1'b0, 1'b0, 300);

    // Async reset mid-stream at slice 3
    load(0, 64'h12345678_9ABCDEF0);
    beat_ptr = 0; word_ptr = 0;
    run(0, 4, 6, 1'b0, 1'b0, 100);
    check("pre_rst_slice", a_oslice, 3);
    check("pre_rst_valid", a_ovalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", a_ovalid, 0);
    check("arst_ready", a_oready, 1);
    check("arst_slice", a_oslice, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", a_ovalid, 0);

    // Synchronous clear mid-fill at beat 2, with a beat offered in the clear cycle
    load(0, 64'h01020304_8000FF0F);
    beat_ptr = 0; word_ptr = 0;
    run(0, 2, 0, 1'b0, 1'b0, 20);
    clr = 1'b1; a_valid = 1'b1; a_data[0] = 8'hEE; a_data[1] = 8'hEE;
    @(posedge clk); #1;
    clr = 1'b0; a_valid = 1'b0;
    check("clr_valid", a_ovalid, 0);
    check("clr_ready", a_oready, 1);
    @(posedge clk); #1;
    check("clr_idle_valid", a_ovalid, 0);

    // Fresh vector streams from slice 0, addr 0
    load(0, 64'hA53C7E11_C39600FF);
    beat_ptr = 0; word_ptr = 0;
    run(0, 4, 16, 1'b0, 1'b0, 100);
    check("recover_s0a0", got[0], 4'h9);
    check("recover_idle", a_ovalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
